round_referee: RTL

Match referee between the collision logic and the game-state sequencer. Consumes per-frame crash flags for the blue and red light cycles and keeps each player's score. At the end of each round it either requests a new round via `Reset_Round` after a fixed inter-round hold, or declares a match winner on `Blue_W` / `Red_W`. Scores are exported to the HUD renderer.

---
 rtl/round_referee.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/round_referee.sv
// Match referee: turns per-frame crash flags into round results, scores and match wins.
// Optional define ROUND_REFEREE_CRASH_LATCH_EN makes crash pulses between frame ticks sticky until the next tick.
module round_referee #(
  parameter int WIN_SCORE   = 3,
  parameter int HOLD_FRAMES = 60,
  parameter int SCORE_W     = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [2:0]         Game_State,
  input  logic               frame_tick,
  input  logic               blue_crash,
  input  logic               red_crash,
  output logic               Reset_Round,
  output logic               Blue_W,
  output logic               Red_W,
  output logic [SCORE_W-1:0] blue_score,
  output logic [SCORE_W-1:0] red_score,
  output logic               round_over,
  output logic               last_draw
);

  localparam int                 CNT_W     = $clog2(HOLD_FRAMES + 1);
  localparam logic [2:0]         GS_MENU   = 3'd0;
  localparam logic [2:0]         GS_START  = 3'd2;
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_FRAMES);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, MATCH_END} state_t;

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic               blue_hit;
  logic               red_hit;
  logic [SCORE_W-1:0] blue_inc;
  logic [SCORE_W-1:0] red_inc;
  logic               in_play;

  assign in_play = (state == PLAY) && (Game_State == GS_START);

`ifdef ROUND_REFEREE_CRASH_LATCH_EN
  logic blue_seen;
  logic red_seen;

  // Sticky flags only gather between ticks; a tick consumes them, as does leaving PLAY.
  always_ff @(posedge Clk) begin
    if (!Reset_n || !in_play || frame_tick) begin
      blue_seen <= 1'b0;
      red_seen  <= 1'b0;
    end else begin
      blue_seen <= blue_seen | blue_crash;
      red_seen  <= red_seen | red_crash;
    end
  end

  assign blue_hit = blue_crash | blue_seen;
  assign red_hit  = red_crash | red_seen;
`else
  assign blue_hit = blue_crash;
  assign red_hit  = red_crash;
`endif

  // Saturating increments: a score parked at WIN_SCORE after a match never wraps.
  assign blue_inc = (blue_score >= WIN) ? WIN : blue_score + SCORE_W'(1);
  assign red_inc  = (red_score  >= WIN) ? WIN : red_score  + SCORE_W'(1);

  // NOTE: all state and outputs are updated with non-blocking assignments so every
  // branch below reads the pre-edge values, regardless of statement order.
  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous; Menu reuses the same clear path because it
    // must override every other state transition.
    if (!Reset_n || Game_State == GS_MENU) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      Reset_Round <= 1'b0;
      Blue_W      <= 1'b0;
      Red_W       <= 1'b0;
      blue_score  <= '0;
      red_score   <= '0;
      round_over  <= 1'b0;
      last_draw   <= 1'b0;
    end else begin
      Reset_Round <= 1'b0;
      case (state)
        IDLE: begin
          if (Game_State == GS_START) state <= PLAY;
        end

        PLAY: begin
          if (Game_State != GS_START) begin
            state <= IDLE;
          end else if (frame_tick) begin
            if (blue_hit && red_hit) begin
              last_draw  <= 1'b1;
              hold_cnt   <= HOLD_LOAD;
              round_over <= 1'b1;
              state      <= HOLD;
            end else if (blue_hit) begin
              last_draw <= 1'b0;
              red_score <= red_inc;
              if (red_inc == WIN) begin
                Red_W <= 1'b1;
                state <= MATCH_END;
              end else begin
                hold_cnt   <= HOLD_LOAD;
                round_over <= 1'b1;
                state      <= HOLD;
              end
            end else if (red_hit) begin
              last_draw  <= 1'b0;
              blue_score <= blue_inc;
              if (blue_inc == WIN) begin
                Blue_W <= 1'b1;
                state  <= MATCH_END;
              end else begin
                hold_cnt   <= HOLD_LOAD;
                round_over <= 1'b1;
                state      <= HOLD;
              end
            end
          end
        end

        HOLD: begin
          if (Game_State != GS_START) begin
            // Sequencer pulled out of the round on its own: drop the hold quietly.
            hold_cnt   <= '0;
            round_over <= 1'b0;
            state      <= IDLE;
          end else if (frame_tick) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
            if (hold_cnt == CNT_W'(1)) begin
              Reset_Round <= 1'b1;
              round_over  <= 1'b0;
              state       <= IDLE;
            end
          end
        end

        MATCH_END: begin
          if (Game_State != GS_START) begin
            Blue_W <= 1'b0;
            Red_W  <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_single_winner : assert property (@(posedge Clk) !(Blue_W && Red_W));

endmodule
